// File: rtl/dt_controller.sv
// Top-level sequencer for the distance-transform block: unpacks the source ROM
// into the result RAM, then hands the shared RAM port to the forward and backward engines.
module dt_controller #(
    parameter int unsigned STI_WORDS    = 1024,
    parameter int unsigned PIX_PER_WORD = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        sti_rd,
    output logic [9:0]  sti_addr,
    input  logic [15:0] sti_di,
    output logic        res_rd,
    output logic        res_wr,
    output logic [13:0] res_addr,
    output logic [7:0]  res_do,
    input  logic [7:0]  res_di,
    output logic        fp_start,
    input  logic        fp_rd,
    input  logic        fp_wr,
    input  logic [13:0] fp_addr,
    input  logic [7:0]  fp_do,
    input  logic        fp_done,
    output logic        bp_go,
    input  logic        bp_rd,
    input  logic        bp_wr,
    input  logic [13:0] bp_addr,
    input  logic [7:0]  bp_do,
    input  logic        bp_done,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W_W = 10;
    localparam int unsigned K_W = 4;
    localparam int unsigned D_W = 8;
    localparam int unsigned S_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_REQ = 3'd1,
        LD_CAP = 3'd2,
        LD_WR  = 3'd3,
        FP_RUN = 3'd4,
        BP_RUN = 3'd5,
        DONE   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [W_W-1:0]   w_q, w_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [S_W-1:0]   sbuf_q, sbuf_d;
    logic             fp_seen_q, fp_seen_d;

    // Read data is consumed by the engines, not by the sequencer.
    logic unused_res_di;
    assign unused_res_di = ^res_di;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            w_q       <= '0;
            k_q       <= '0;
            sbuf_q    <= '0;
            fp_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            k_q       <= k_d;
            sbuf_q    <= sbuf_d;
            fp_seen_q <= fp_seen_d;
        end
    end

    // Next state plus output decode; the RAM mux follows the state register only.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        k_d       = k_q;
        sbuf_d    = sbuf_q;
        fp_seen_d = (state_q == FP_RUN);
        sti_rd    = 1'b0;
        sti_addr  = '0;
        res_rd    = 1'b0;
        res_wr    = 1'b0;
        res_addr  = '0;
        res_do    = '0;
        fp_start  = 1'b0;
        bp_go     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                w_d  = '0;
                k_d  = '0;
                if (start) begin
                    state_d = LD_REQ;
                end
            end
            LD_REQ: begin
                sti_rd   = 1'b1;
                sti_addr = w_q;
                state_d  = LD_CAP;
            end
            LD_CAP: begin
                sbuf_d  = sti_di;
                k_d     = '0;
                state_d = LD_WR;
            end
            LD_WR: begin
                // Buffer shifts left so the current pixel is always the MSB.
                res_wr   = 1'b1;
                res_addr = {w_q, k_q};
                res_do   = D_W'(sbuf_q[S_W-1]);
                sbuf_d   = sbuf_q << 1;
                k_d      = k_q + K_W'(1);
                if (k_q == K_W'(PIX_PER_WORD - 1)) begin
                    if (w_q == W_W'(STI_WORDS - 1)) begin
                        state_d = FP_RUN;
                    end else begin
                        w_d     = w_q + W_W'(1);
                        state_d = LD_REQ;
                    end
                end
            end
            FP_RUN: begin
                fp_start = !fp_seen_q;
                res_rd   = fp_rd;
                res_wr   = fp_wr;
                res_addr = fp_addr;
                res_do   = fp_do;
                if (fp_done) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                bp_go    = 1'b1;
                res_rd   = bp_rd;
                res_wr   = bp_wr;
                res_addr = bp_addr;
                res_do   = bp_do;
                if (bp_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy  = 1'b0;
                done  = 1'b1;
                bp_go = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dt_controller.sv
// Randomized bench for dt_controller: a cycle-count reference model predicts every
// output each cycle from the load schedule and the completion pulses the bench drives.
module tb_dt_controller;

    localparam int N = 1024;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_FP   = 2;
    localparam int M_BP   = 3;
    localparam int M_DONE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic        res_rd, res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [7:0]  res_di;
    logic        fp_start;
    logic        fp_rd, fp_wr;
    logic [13:0] fp_addr;
    logic [7:0]  fp_do;
    logic        fp_done;
    logic        bp_go;
    logic        bp_rd, bp_wr;
    logic [13:0] bp_addr;
    logic [7:0]  bp_do;
    logic        bp_done;
    logic        busy, done;

    dt_controller #(.STI_WORDS(N), .PIX_PER_WORD(16)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di),
        .fp_start(fp_start), .fp_rd(fp_rd), .fp_wr(fp_wr), .fp_addr(fp_addr), .fp_do(fp_do),
        .fp_done(fp_done),
        .bp_go(bp_go), .bp_rd(bp_rd), .bp_wr(bp_wr), .bp_addr(bp_addr), .bp_do(bp_do),
        .bp_done(bp_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Source ROM: one-cycle read latency, junk on the bus when not read.
    logic [15:0] rom [N];
    always @(posedge clk) begin
        if (sti_rd) sti_di <= rom[sti_addr];
        else        sti_di <= 16'($urandom);
    end

    logic [38:0] dut_vec;
    assign dut_vec = {busy, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do, fp_start, bp_go};

    int n_chk  = 0;
    int n_pass = 0;

    int region = M_IDLE;
    int t = 0, fp_t = 0, bp_t = 0, run_t = 0;
    bit want_start = 1'b0;
    bit run_a = 1'b0;

    int n_rd = 0;
    int rd_cyc [2];
    int fp_cnt = 0, fp_cyc = 0, done_cyc = 0, bp_done_cyc = 0;
    logic [15:0] pix0 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [38:0] model_vec();
        logic b, d, srd, rrd, rwr, fs, bg;
        logic [9:0]  sa;
        logic [13:0] ra;
        logic [7:0]  rdo;
        int idx, wd, ph;
        b = 0; d = 0; srd = 0; rrd = 0; rwr = 0; fs = 0; bg = 0;
        sa = '0; ra = '0; rdo = '0;
        case (region)
            M_LOAD: begin
                b   = 1;
                idx = t - 1;
                wd  = idx / 18;
                ph  = idx % 18;
                if (ph == 0) begin
                    srd = 1;
                    sa  = 10'(wd);
                end else if (ph >= 2) begin
                    rwr = 1;
                    ra  = 14'(wd * 16 + ph - 2);
                    rdo = {7'd0, rom[wd][15 - (ph - 2)]};
                end
            end
            M_FP: begin
                b = 1; fs = (fp_t == 0);
                rrd = fp_rd; rwr = fp_wr; ra = fp_addr; rdo = fp_do;
            end
            M_BP: begin
                b = 1; bg = 1;
                rrd = bp_rd; rwr = bp_wr; ra = bp_addr; rdo = bp_do;
            end
            M_DONE: begin
                d = 1; bg = 1;
            end
            default: ;
        endcase
        return {b, d, srd, sa, rrd, rwr, ra, rdo, fs, bg};
    endfunction

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic step();
        fp_rd   = 1'($urandom);  fp_wr = 1'($urandom);
        fp_addr = 14'($urandom); fp_do = 8'($urandom);
        bp_rd   = 1'($urandom);  bp_wr = 1'($urandom);
        bp_addr = 14'($urandom); bp_do = 8'($urandom);
        res_di  = 8'($urandom);
        if (region == M_FP && fp_t >= 10 && fp_t < 20) begin
            fp_wr = 0; bp_wr = 1; bp_addr = 14'h1234;
        end
        if (region == M_BP && bp_t < 6) begin
            bp_rd = 0; bp_wr = 1; bp_addr = 14'h1234;
        end
        if (region == M_FP)                            fp_done = (fp_t == 50);
        else if (region == M_BP || region == M_DONE)   fp_done = 1'b1;
        else                                           fp_done = ($urandom_range(0, 7) == 0);
        if (region == M_BP)        bp_done = (bp_t == 40);
        else if (region == M_DONE) bp_done = 1'b1;
        else                       bp_done = ($urandom_range(0, 7) == 0);
        start = want_start || (region != M_IDLE && $urandom_range(0, 63) == 0);
        if (region == M_LOAD && t == 5 * 18 + 3) start = 1'b1;
        #1;
        chk($sformatf("cycle r%0d t%0d", region, run_t), 64'(dut_vec), 64'(model_vec()));
        if (region == M_FP && fp_t >= 10 && fp_t < 20)
            chk("fp_blocks_bp_wr", 64'(res_wr), 64'd0);
        if (region == M_BP && bp_t < 6)
            chk("bp_owns_port", 64'({res_wr, res_addr}), 64'({1'b1, 14'h1234}));
        if (run_a) begin
            if (sti_rd && n_rd < 2) begin rd_cyc[n_rd] = run_t; n_rd++; end
            if (fp_start) begin fp_cnt++; fp_cyc = run_t; end
            if (done && done_cyc == 0) done_cyc = run_t;
            if (region == M_BP && bp_done) bp_done_cyc = run_t;
            if (region == M_LOAD && res_wr && res_addr < 14'd16) pix0[15 - int'(res_addr)] = res_do[0];
        end
        @(posedge clk);
        case (region)
            M_IDLE: if (start) begin region = M_LOAD; t = 1; run_t = 1; end
            M_LOAD: begin
                t++; run_t++;
                if (t > 18 * N) begin region = M_FP; fp_t = 0; end
            end
            M_FP: begin
                run_t++;
                if (fp_done) begin region = M_BP; bp_t = 0; end
                else fp_t++;
            end
            M_BP: begin
                run_t++;
                if (bp_done) region = M_DONE;
                else bp_t++;
            end
            default: run_t++;
        endcase
        want_start = 1'b0;
        #1;
    endtask

    // Asynchronous reset with engines hammering the port; outputs must drop at once.
    task automatic do_reset();
        fp_rd = 1; fp_wr = 1; fp_addr = 14'h1234; fp_do = 8'hff;
        bp_rd = 1; bp_wr = 1; bp_addr = 14'h1234; bp_do = 8'hff;
        start = 0;
        rstn  = 0;
        #1;
        chk("async_reset", 64'(dut_vec), 64'd0);
        region = M_IDLE; t = 0; run_t = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset_hold", 64'(dut_vec), 64'd0);
        end
        rstn = 1;
    endtask

    initial begin
        rstn = 0; start = 0; res_di = '0;
        fp_rd = 0; fp_wr = 0; fp_addr = '0; fp_do = '0; fp_done = 0;
        bp_rd = 0; bp_wr = 0; bp_addr = '0; bp_do = '0; bp_done = 0;
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h8001;
        #1;
        chk("reset_outputs", 64'(dut_vec), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1;

        // Run A: full sequence to DONE.
        repeat (4) step();
        run_a = 1'b1;
        want_start = 1'b1;
        step();
        for (int g = 0; g < 30000 && region != M_DONE; g++) step();
        for (int i = 0; i < 20; i++) begin
            want_start = (i % 4 == 0);
            step();
        end
        run_a = 1'b0;
        chk("sti_rd_first", 64'(rd_cyc[0]), 64'd1);
        chk("sti_rd_second", 64'(rd_cyc[1]), 64'd19);
        chk("word0_pixels", 64'(pix0), 64'h8001);
        chk("fp_start_count", 64'(fp_cnt), 64'd1);
        chk("fp_start_cycle", 64'(fp_cyc), 64'(18 * N + 1));
        chk("done_rise", 64'(done_cyc), 64'(bp_done_cyc + 1));

        // Run B: reset while the forward pass is running, then restart.
        do_reset();
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        repeat (3) step();
        want_start = 1'b1;
        step();
        for (int g = 0; g < 30000 && !(region == M_FP && fp_t == 10); g++) step();
        do_reset();
        repeat (5) step();

        // Run C: reload from word 0, then abort mid-load.
        want_start = 1'b1;
        step();
        for (int g = 0; g < 1000 && t < 200; g++) step();
        do_reset();
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
